sobel_filter: RTL and testbench
===============================

// Module: sobel_filter
// PURPOSE
//  Streaming 3x3 Sobel edge detector on the PCIe packet datapath. Accepts one RGB pixel per
//  valid beat in raster order and converts it to 8-bit grayscale. Emits one 8-bit edge-magnitude
//  pixel per accepted beat after a fixed latency. No backpressure; sits between PCIe RX and TX.
// PARAMETERS
//  IMG_WIDTH   512  pixels per image row; sets line-buffer depth (2 x IMG_WIDTH x 8 bit)
//  COL_W       $clog2(IMG_WIDTH)  column counter width
// PORTS
//  clk              input   1       sole clock, rising edge
//  rst              input   1       asynchronous, active-low reset
//  pcie_packet_in   input   PCIEPacket  {valid, data[127:0], slot[15:0], pad[3:0], last}
//  pcie_packet_out  output  PCIEPacket  result beat, same struct
// BEHAVIOUR
//  - Input pixel: R=data[7:0], G=data[15:8], B=data[23:16]; data[127:24] ignored.
//  - Beat accepted when pcie_packet_in.valid=1; no ready signal, every valid beat is consumed.
//  - Gray = (R + 2*G + B) >> 2, 10-bit sum truncated to 8 bits (255,255,255 -> 255).
//  - Two line buffers hold the gray values of the previous two rows. Row/col counters track
//    position: col increments per beat and wraps at IMG_WIDTH-1, incrementing row.
//  - The 3x3 window p[r][c] (r,c=0..2) is built from the last 3 gray pixels of rows
//    row-2, row-1 and row. p[2][2] is the current pixel.
//  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)
//  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)
//  - Gx/Gy are 11-bit signed. mag = |Gx| + |Gy|, saturated to 255.
//  - Border: if row<2 or col<2 at the accepted beat, mag is forced to 0. Stale line-buffer and
//    window contents are never visible at the output.
//  - Output pixel k corresponds to window centre (row-1, col-1) of input beat k. The output
//    image is shifted one row/col; output count equals input count.
//  - Pipeline: S1 = gray + window shift + line-buffer write; S2 = Gx/Gy; S3 = abs/sum/saturate.
//    Latency: 3 clk from accepted input beat to out.valid=1.
//  - Output fields:
//    - out.valid = in.valid delayed 3 clk.
//    - out.data = {120'h0, mag}.
//    - out.slot and out.last = input values delayed 3 clk.
//    - out.pad = 0.
//  - Beats with in.valid=0 are bubbles. The pipeline advances every clk; bubbles do not change
//    counters, window or line buffers.
//  - in.last=1 on an accepted beat ends the frame: after that beat, row and col return to 0.
//    Line buffers are not cleared.
//  - Reset (rst=0, async): out.valid=0, out.data=0, out.slot=0, out.last=0, row=col=0, and all
//    pipeline valid bits cleared. Line-buffer RAM is not reset. Reset mid-frame discards
//    in-flight beats; the first beat after release is pixel (0,0).
//  - Back-to-back valid beats are sustained at 1 pixel/clk indefinitely.
// TESTING
//  1 Reset: hold rst=0 with in.valid=1 -> out.valid=0 and out.data=0 throughout; after release,
//    out.valid=1 first appears exactly 3 clk after the first valid beat.
//  2 Uniform frame, IMG_WIDTH=4, 4x4 pixels all (100,100,100) -> 16 output beats, all data=0.
//  3 Vertical edge, IMG_WIDTH=4: cols 0-1 = (0,0,0), cols 2-3 = (255,255,255) ->
//    row>=2: col2 output 255 (Gx=1020, saturated), col3 output 255; rows 0-1 output 0.
//  4 Gray/weighting: R=255,G=0,B=0 -> gray 63. Single-pixel step 0->63 at (2,2) in a zero field
//    -> output at that beat = 63 + 63 = 126.
//  5 Bubbles and last: insert valid=0 gaps mid-row -> same output values as the gapless stream.
//    A beat with last=1 -> next beat is treated as row0/col0, output 0, out.last=1 3 clk later.
//  6 Mid-frame reset: assert rst=0 for 1 clk during row 2 -> no output for in-flight beats;
//    the next frame matches scenario 3 exactly.

Source files
------------

// File: rtl/sobel_filter_if.sv
// Packet beat carried on the PCIe RX/TX datapath around the Sobel filter.
// The master drives a beat, the slave samples it; there is no backpressure.
interface sobel_filter_if;
    logic         valid;
    logic [127:0] data;
    logic [15:0]  slot;
    logic [3:0]   pad;
    logic         last;

    modport master (output valid, data, slot, pad, last);
    modport slave  (input  valid, data, slot, pad, last);
endinterface

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge detector: RGB pixel in, 8-bit edge magnitude out,
// three register stages, one pixel per clock, no backpressure.
module sobel_filter #(
    parameter int IMG_WIDTH = 512,
    parameter int COL_W     = $clog2(IMG_WIDTH)
) (
    input  logic           clk,
    input  logic           rst,
    sobel_filter_if.slave  pcie_packet_in,
    sobel_filter_if.master pcie_packet_out
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    function automatic logic [7:0] to_gray(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
        logic [9:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[9:2];
    endfunction

    function automatic logic signed [10:0] ext11(input logic [7:0] p);
        return signed'({3'b000, p});
    endfunction

    // Shared form of Gx and Gy: weighted (1,2,1) positive side minus negative side.
    function automatic logic signed [10:0] grad(input logic [7:0] pa, input logic [7:0] pb,
                                                input logic [7:0] pc, input logic [7:0] na,
                                                input logic [7:0] nb, input logic [7:0] nc);
        return (ext11(pa) + (ext11(pb) <<< 1) + ext11(pc))
             - (ext11(na) + (ext11(nb) <<< 1) + ext11(nc));
    endfunction

    function automatic logic [10:0] abs11(input logic signed [10:0] v);
        return v[10] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [7:0] sat_mag(input logic signed [10:0] gx,
                                           input logic signed [10:0] gy);
        logic [11:0] sum;
        sum = {1'b0, abs11(gx)} + {1'b0, abs11(gy)};
        return (sum > 12'd255) ? 8'hFF : sum[7:0];
    endfunction

    logic unused_in;
    assign unused_in = ^{pcie_packet_in.data[127:24], pcie_packet_in.pad};

    logic             acc;
    logic [7:0]       gray;
    logic [7:0]       lb1_rd;
    logic [7:0]       lb2_rd;
    logic [COL_W-1:0] col_q, col_d;
    logic [1:0]       row_q, row_d;

    logic [7:0] lb1_q [IMG_WIDTH];
    logic [7:0] lb2_q [IMG_WIDTH];

    logic [2:0][2:0][7:0] win_q, win_d;
    logic                 vld_p1_q, vld_p1_d;
    logic                 border_p1_q, border_p1_d;
    logic [15:0]          slot_p1_q, slot_p1_d;
    logic                 last_p1_q, last_p1_d;

    logic signed [10:0] gx_p2_q, gx_p2_d;
    logic signed [10:0] gy_p2_q, gy_p2_d;
    logic               vld_p2_q, vld_p2_d;
    logic               border_p2_q, border_p2_d;
    logic [15:0]        slot_p2_q, slot_p2_d;
    logic               last_p2_q, last_p2_d;

    logic        vld_p3_q, vld_p3_d;
    logic [7:0]  mag_p3_q, mag_p3_d;
    logic [15:0] slot_p3_q, slot_p3_d;
    logic        last_p3_q, last_p3_d;

    assign acc    = pcie_packet_in.valid;
    assign gray   = to_gray(pcie_packet_in.data[7:0], pcie_packet_in.data[15:8],
                            pcie_packet_in.data[23:16]);
    assign lb1_rd = lb1_q[col_q];
    assign lb2_rd = lb2_q[col_q];

    // Stage 1: position tracking, window shift, line-buffer update
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        vld_p1_d    = acc;
        border_p1_d = (row_q < 2'd2) || (col_q < COL_W'(2));
        slot_p1_d   = pcie_packet_in.slot;
        last_p1_d   = pcie_packet_in.last;
        if (acc) begin
            if (pcie_packet_in.last) begin
                col_d = '0;
                row_d = '0;
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == 2'd2) ? 2'd2 : 2'(row_q + 2'd1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb2_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = gray;
        end
    end

    // Stage 2: gradients; win_q[r][c] holds row (row-2+r), column (col-2+c)
    always_comb begin
        gx_p2_d     = grad(win_q[0][2], win_q[1][2], win_q[2][2],
                           win_q[0][0], win_q[1][0], win_q[2][0]);
        gy_p2_d     = grad(win_q[2][0], win_q[2][1], win_q[2][2],
                           win_q[0][0], win_q[0][1], win_q[0][2]);
        vld_p2_d    = vld_p1_q;
        border_p2_d = border_p1_q;
        slot_p2_d   = slot_p1_q;
        last_p2_d   = last_p1_q;
    end

    // Stage 3: magnitude with saturation, border suppression
    always_comb begin
        vld_p3_d  = vld_p2_q;
        mag_p3_d  = border_p2_q ? 8'h00 : sat_mag(gx_p2_q, gy_p2_q);
        slot_p3_d = slot_p2_q;
        last_p3_d = last_p2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q     <= '0;
            row_q     <= '0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_p3_q  <= 1'b0;
            mag_p3_q  <= '0;
            slot_p3_q <= '0;
            last_p3_q <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            vld_p3_q  <= vld_p3_d;
            mag_p3_q  <= mag_p3_d;
            slot_p3_q <= slot_p3_d;
            last_p3_q <= last_p3_d;
        end
    end

    // Datapath state is never reset; the border flag hides anything stale.
    always_ff @(posedge clk) begin
        win_q       <= win_d;
        border_p1_q <= border_p1_d;
        slot_p1_q   <= slot_p1_d;
        last_p1_q   <= last_p1_d;
        gx_p2_q     <= gx_p2_d;
        gy_p2_q     <= gy_p2_d;
        border_p2_q <= border_p2_d;
        slot_p2_q   <= slot_p2_d;
        last_p2_q   <= last_p2_d;
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            lb1_q[col_q] <= gray;
            lb2_q[col_q] <= lb1_rd;
        end
    end

    assign pcie_packet_out.valid = vld_p3_q;
    assign pcie_packet_out.data  = {120'h0, mag_p3_q};
    assign pcie_packet_out.slot  = slot_p3_q;
    assign pcie_packet_out.pad   = '0;
    assign pcie_packet_out.last  = last_p3_q;

endmodule

// File: tb/tb_sobel_filter.sv
// Randomized bench for sobel_filter (IMG_WIDTH=4) against a frame-image reference model.
module tb_sobel_filter;
    localparam int W = 4;

    logic clk;
    logic rst;
    sobel_filter_if in_if();
    sobel_filter_if out_if();

    sobel_filter #(.IMG_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .pcie_packet_in (in_if),
        .pcie_packet_out(out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [7:0]  mag;
        logic [15:0] slot;
        logic        last;
    } exp_t;

    exp_t expq[$];
    int   img [64][W];
    int   m_row;
    int   m_col;
    int   cyc;
    int   total;
    int   bad;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: keep the whole frame as gray values and apply the Sobel kernel directly.
    function automatic int ref_mag(input int r, input int c);
        int gx;
        int gy;
        int s;
        if (r < 2 || c < 2) return 0;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        s = iabs(gx) + iabs(gy);
        return (s > 255) ? 255 : s;
    endfunction

    task automatic step(input bit v, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input bit lst, input bit rstv);
        logic [127:0] d;
        logic [15:0]  slot;
        exp_t         e;
        d     = {$urandom(), $urandom(), $urandom(), $urandom()};
        d[23:0] = {b, g, r};
        slot  = 16'($urandom());
        in_if.valid = v;
        in_if.data  = d;
        in_if.slot  = slot;
        in_if.pad   = 4'($urandom());
        in_if.last  = lst;
        rst         = rstv;
        @(posedge clk);
        #1;
        cyc++;
        if (!rstv) begin
            expq.delete();
            m_row = 0;
            m_col = 0;
        end else if (v) begin
            if (m_row < 64) img[m_row][m_col] = (int'(r) + 2*int'(g) + int'(b)) >> 2;
            e.cyc  = cyc + 2;
            e.mag  = 8'(ref_mag(m_row, m_col));
            e.slot = slot;
            e.last = lst;
            expq.push_back(e);
            if (lst) begin
                m_row = 0;
                m_col = 0;
            end else if (m_col == W-1) begin
                m_col = 0;
                m_row++;
            end else begin
                m_col++;
            end
        end
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
            e = expq.pop_front();
            check_eq("out_valid", 128'(out_if.valid), 128'(1));
            check_eq("out_data", out_if.data, {120'h0, e.mag});
            check_eq("out_slot", 128'(out_if.slot), 128'(e.slot));
            check_eq("out_last", 128'(out_if.last), 128'(e.last));
            check_eq("out_pad", 128'(out_if.pad), 128'(0));
        end else begin
            check_eq("idle_valid", 128'(out_if.valid), 128'(0));
            if (!rstv) begin
                check_eq("rst_data", out_if.data, 128'(0));
                check_eq("rst_slot", 128'(out_if.slot), 128'(0));
                check_eq("rst_last", 128'(out_if.last), 128'(0));
            end
        end
    endtask

    // kind: 0 uniform 100, 1 vertical edge, 2 single red pixel at (2,2), 3 random
    task automatic pixel(input int kind, input int r, input int c,
                         output logic [7:0] pr, output logic [7:0] pg, output logic [7:0] pb);
        pr = 8'd0; pg = 8'd0; pb = 8'd0;
        case (kind)
            0: begin pr = 8'd100; pg = 8'd100; pb = 8'd100; end
            1: if (c >= 2) begin pr = 8'hFF; pg = 8'hFF; pb = 8'hFF; end
            2: if (r == 2 && c == 2) pr = 8'hFF;
            default: begin pr = 8'($urandom()); pg = 8'($urandom()); pb = 8'($urandom()); end
        endcase
    endtask

    task automatic run_frame(input int kind, input int rows, input int bub_pct);
        logic [7:0] pr, pg, pb;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < W; c++) begin
                while ($urandom_range(99) < bub_pct) step(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
                pixel(kind, r, c, pr, pg, pb);
                step(1'b1, pr, pg, pb, (r == rows-1) && (c == W-1), 1'b1);
            end
        end
    endtask

    initial begin
        logic [7:0] pr, pg, pb;
        total = 0;
        bad   = 0;
        cyc   = 0;
        m_row = 0;
        m_col = 0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < W; c++) img[r][c] = 0;
        rst         = 1'b0;
        in_if.valid = 1'b0;
        in_if.data  = '0;
        in_if.slot  = '0;
        in_if.pad   = '0;
        in_if.last  = 1'b0;

        for (int i = 0; i < 4; i++) step(1'b1, 8'd50, 8'd60, 8'd70, 1'b0, 1'b0);
        run_frame(0, 4, 0);
        run_frame(1, 4, 0);
        run_frame(2, 4, 0);
        run_frame(1, 4, 30);

        // Frame ended early by last in the middle of row 1, then a full frame.
        for (int i = 0; i < 6; i++) step(1'b1, 8'hFF, 8'h10, 8'h80, i == 5, 1'b1);
        run_frame(3, 4, 0);

        // Reset during row 2, then the vertical-edge frame again.
        for (int i = 0; i < 2*W + 2; i++) begin
            pixel(1, i / W, i % W, pr, pg, pb);
            step(1'b1, pr, pg, pb, 1'b0, 1'b1);
        end
        step(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_frame(1, 4, 0);

        for (int f = 0; f < 12; f++) run_frame(3, $urandom_range(3, 6), $urandom_range(0, 40));
        for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        check_eq("queue_drained", 128'(expq.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
